// File: rtl/id_exe_stage_reg_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : id_exe_stage_reg_if                                            |
// | Brief   : Decode-side and Execute-side bundle for the ID/EXE register.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface id_exe_stage_reg_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
);
  logic            ID_valid;
  logic [4:0]      ID_rs1;
  logic [4:0]      ID_rs2;
  logic [4:0]      ID_rd;
  logic [6:0]      ID_OPCODE;
  logic            ID_RegWrite;
  logic            ID_MemRead;
  logic            ID_MemWrite;
  logic [XLEN-1:0] ID_rs1_data;
  logic [XLEN-1:0] ID_rs2_data;
  logic [XLEN-1:0] ID_imm;
  logic [XLEN-1:0] ID_pc;
  logic            flush;

  logic            ID_EXE_valid;
  logic [4:0]      ID_EXE_rs1;
  logic [4:0]      ID_EXE_rs2;
  logic [4:0]      ID_EXE_rd;
  logic [6:0]      ID_EXE_OPCODE;
  logic            ID_EXE_RegWrite;
  logic            ID_EXE_MemRead;
  logic            ID_EXE_MemWrite;
  logic [XLEN-1:0] ID_EXE_rs1_data;
  logic [XLEN-1:0] ID_EXE_rs2_data;
  logic [XLEN-1:0] ID_EXE_imm;
  logic [XLEN-1:0] ID_EXE_pc;
  logic            stall_IF_ID;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ID_valid, ID_rs1, ID_rs2, ID_rd, ID_OPCODE,
           ID_RegWrite, ID_MemRead, ID_MemWrite,
           ID_rs1_data, ID_rs2_data, ID_imm, ID_pc, flush,
    input  ID_EXE_valid, ID_EXE_rs1, ID_EXE_rs2, ID_EXE_rd, ID_EXE_OPCODE,
           ID_EXE_RegWrite, ID_EXE_MemRead, ID_EXE_MemWrite,
           ID_EXE_rs1_data, ID_EXE_rs2_data, ID_EXE_imm, ID_EXE_pc,
           stall_IF_ID, stall_count, flush_count
  );

  modport slave (
    input  ID_valid, ID_rs1, ID_rs2, ID_rd, ID_OPCODE,
           ID_RegWrite, ID_MemRead, ID_MemWrite,
           ID_rs1_data, ID_rs2_data, ID_imm, ID_pc, flush,
    output ID_EXE_valid, ID_EXE_rs1, ID_EXE_rs2, ID_EXE_rd, ID_EXE_OPCODE,
           ID_EXE_RegWrite, ID_EXE_MemRead, ID_EXE_MemWrite,
           ID_EXE_rs1_data, ID_EXE_rs2_data, ID_EXE_imm, ID_EXE_pc,
           stall_IF_ID, stall_count, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/id_exe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : id_exe_stage_reg                                               |
// | Brief   : ID/EXE pipeline register with load-use hazard detection,       |
// |           bubble insertion and saturating stall/flush counters.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module id_exe_stage_reg #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  id_exe_stage_reg_if.slave  bus
);
  localparam logic [6:0] c_OP_NOP     = 7'h13;
  localparam logic [6:0] c_OP_OPIMM   = 7'h13;
  localparam logic [6:0] c_OP_OPIMM32 = 7'h1b;
  localparam logic [6:0] c_OP_LOAD    = 7'h03;
  localparam logic [6:0] c_OP_JAL     = 7'h6f;
  localparam logic [6:0] c_OP_JALR    = 7'h67;
  localparam logic [6:0] c_OP_LUI     = 7'h37;
  localparam logic [6:0] c_OP_AUIPC   = 7'h17;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic w_uses_rs1;
  logic w_uses_rs2;
  logic w_hazard;
  logic w_capture;

  logic            r_valid;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [6:0]      r_opcode;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  always_comb begin
    w_uses_rs1 = 1'b1;
    w_uses_rs2 = 1'b1;
    case (bus.ID_OPCODE)
      c_OP_LUI, c_OP_AUIPC, c_OP_JAL: begin
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
      end
      c_OP_OPIMM, c_OP_OPIMM32, c_OP_LOAD, c_OP_JALR: w_uses_rs2 = 1'b0;
      default: ;
    endcase
  end

  // A load in EXE whose destination is read by ID cannot be forwarded yet.
  assign w_hazard = bus.ID_valid & r_valid & r_mem_read & (r_rd != 5'd0) &
                    ((w_uses_rs1 & (r_rd == bus.ID_rs1)) |
                     (w_uses_rs2 & (r_rd == bus.ID_rs2)));
  assign w_capture = bus.ID_valid & ~bus.flush & ~w_hazard;

  always_ff @(posedge clk) begin
    if (!rst_n || !w_capture) begin
      r_valid     <= 1'b0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_opcode    <= c_OP_NOP;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
    end else begin
      r_valid     <= 1'b1;
      r_rs1       <= bus.ID_rs1;
      r_rs2       <= bus.ID_rs2;
      r_rd        <= bus.ID_rd;
      r_opcode    <= bus.ID_OPCODE;
      r_reg_write <= bus.ID_RegWrite;
      r_mem_read  <= bus.ID_MemRead;
      r_mem_write <= bus.ID_MemWrite;
      r_rs1_data  <= bus.ID_rs1_data;
      r_rs2_data  <= bus.ID_rs2_data;
      r_imm       <= bus.ID_imm;
      r_pc        <= bus.ID_pc;
    end
  end

  // Flush outranks the hazard, so only one counter moves per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else if (bus.flush) begin
      if (!(&r_flush_count)) r_flush_count <= r_flush_count + c_CNT_ONE;
    end else if (w_hazard) begin
      if (!(&r_stall_count)) r_stall_count <= r_stall_count + c_CNT_ONE;
    end
  end

  assign bus.stall_IF_ID     = w_hazard & ~bus.flush;
  assign bus.ID_EXE_valid    = r_valid;
  assign bus.ID_EXE_rs1      = r_rs1;
  assign bus.ID_EXE_rs2      = r_rs2;
  assign bus.ID_EXE_rd       = r_rd;
  assign bus.ID_EXE_OPCODE   = r_opcode;
  assign bus.ID_EXE_RegWrite = r_reg_write;
  assign bus.ID_EXE_MemRead  = r_mem_read;
  assign bus.ID_EXE_MemWrite = r_mem_write;
  assign bus.ID_EXE_rs1_data = r_rs1_data;
  assign bus.ID_EXE_rs2_data = r_rs2_data;
  assign bus.ID_EXE_imm      = r_imm;
  assign bus.ID_EXE_pc       = r_pc;
  assign bus.stall_count     = r_stall_count;
  assign bus.flush_count     = r_flush_count;
endmodule
`default_nettype wire

// File: tb/tb_id_exe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_id_exe_stage_reg                                            |
// | Brief   : Directed and random checks of id_exe_stage_reg vs a model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_id_exe_stage_reg;
  localparam int XLEN  = 64;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic last_stall;

  id_exe_stage_reg_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  id_exe_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model of what EXE currently holds, plus the two event totals.
  logic            m_valid, m_rw, m_mr, m_mw;
  logic [4:0]      m_rs1, m_rs2, m_rd;
  logic [6:0]      m_op;
  logic [XLEN-1:0] m_d1, m_d2, m_imm, m_pc;
  int              m_sc, m_fc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op inside {7'h37, 7'h17, 7'h6f});
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return !(op inside {7'h1b, 7'h13, 7'h03, 7'h6f, 7'h67, 7'h37, 7'h17});
  endfunction

  function automatic bit model_hazard();
    bit dep;
    dep = (reads_rs1(bus.ID_OPCODE) && bus.ID_rs1 == m_rd) ||
          (reads_rs2(bus.ID_OPCODE) && bus.ID_rs2 == m_rd);
    return bus.ID_valid && m_valid && m_mr && m_rd != 0 && dep;
  endfunction

  task automatic model_bubble();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 7'h13;
    m_d1 = 0; m_d2 = 0; m_imm = 0; m_pc = 0;
  endtask

  // Inputs are already set; check the stall, clock once, advance the model, check EXE.
  task automatic cycle();
    bit hz;
    hz = model_hazard();
    #1;
    last_stall = bus.stall_IF_ID;
    check("stall_IF_ID", bus.stall_IF_ID, hz && !bus.flush);
    @(posedge clk);
    if (!rst_n) begin
      model_bubble(); m_sc = 0; m_fc = 0;
    end else if (bus.flush) begin
      model_bubble(); if (m_fc < CMAX) m_fc = m_fc + 1;
    end else if (hz) begin
      model_bubble(); if (m_sc < CMAX) m_sc = m_sc + 1;
    end else if (!bus.ID_valid) begin
      model_bubble();
    end else begin
      m_valid = 1; m_rs1 = bus.ID_rs1; m_rs2 = bus.ID_rs2; m_rd = bus.ID_rd;
      m_op = bus.ID_OPCODE; m_rw = bus.ID_RegWrite; m_mr = bus.ID_MemRead;
      m_mw = bus.ID_MemWrite; m_d1 = bus.ID_rs1_data; m_d2 = bus.ID_rs2_data;
      m_imm = bus.ID_imm; m_pc = bus.ID_pc;
    end
    #1;
    check("valid",    bus.ID_EXE_valid,    m_valid);
    check("rs1",      bus.ID_EXE_rs1,      m_rs1);
    check("rs2",      bus.ID_EXE_rs2,      m_rs2);
    check("rd",       bus.ID_EXE_rd,       m_rd);
    check("opcode",   bus.ID_EXE_OPCODE,   m_op);
    check("regwrite", bus.ID_EXE_RegWrite, m_rw);
    check("memread",  bus.ID_EXE_MemRead,  m_mr);
    check("memwrite", bus.ID_EXE_MemWrite, m_mw);
    check("rs1_data", bus.ID_EXE_rs1_data, m_d1);
    check("rs2_data", bus.ID_EXE_rs2_data, m_d2);
    check("imm",      bus.ID_EXE_imm,      m_imm);
    check("pc",       bus.ID_EXE_pc,       m_pc);
    check("stall_count", bus.stall_count, m_sc);
    check("flush_count", bus.flush_count, m_fc);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic rw, input logic mr);
    bus.ID_valid = 1; bus.ID_OPCODE = op;
    bus.ID_rs1 = rs1; bus.ID_rs2 = rs2; bus.ID_rd = rd;
    bus.ID_RegWrite = rw; bus.ID_MemRead = mr; bus.ID_MemWrite = 0;
    bus.ID_rs1_data = {$urandom, $urandom}; bus.ID_rs2_data = {$urandom, $urandom};
    bus.ID_imm = {$urandom, $urandom}; bus.ID_pc = {$urandom, $urandom};
    bus.flush = 0;
  endtask

  task automatic rand_inputs();
    logic [6:0] ops [11] = '{7'h03, 7'h33, 7'h13, 7'h1b, 7'h6f, 7'h67,
                             7'h37, 7'h17, 7'h23, 7'h63, 7'h3b};
    set_instr(ops[$urandom_range(0, 10)],
              ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom_range(0, 31)),
              ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
    bus.ID_MemWrite = 1'($urandom);
    bus.ID_valid = ($urandom_range(0, 7) != 0);
    bus.flush = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; last_stall = 0;
    clk = 0; rst_n = 0;
    model_bubble(); m_sc = 0; m_fc = 0;
    rand_inputs();
    @(posedge clk);
    @(negedge clk);

    // Reset with random inputs
    repeat (2) begin rand_inputs(); cycle(); end
    check("reset_opcode", bus.ID_EXE_OPCODE, 7'h13);
    check("reset_scount", bus.stall_count, 0);
    rst_n = 1;

    // add x6,x5,x7
    set_instr(7'h33, 5, 7, 6, 1, 0); cycle();
    check("pt_stall", last_stall, 0);
    check("pt_rd", bus.ID_EXE_rd, 6);
    check("pt_valid", bus.ID_EXE_valid, 1);

    // ld x5 ; add x6,x7,x5
    set_instr(7'h03, 1, 0, 5, 1, 1); cycle();
    set_instr(7'h33, 7, 5, 6, 1, 0); cycle();
    check("lu_stall", last_stall, 1);
    check("lu_bubble", bus.ID_EXE_valid, 0);
    cycle();
    check("lu_release", last_stall, 0);
    check("lu_capture", bus.ID_EXE_rs2, 5);
    check("lu_scount", bus.stall_count, 1);

    // ld x5 ; addi x6,x1 with rs2 field 5
    set_instr(7'h03, 1, 0, 5, 1, 1); cycle();
    set_instr(7'h13, 1, 5, 6, 1, 0); cycle();
    check("addi_nostall", last_stall, 0);
    // ld x0 ; add x6,x0,x0
    set_instr(7'h03, 1, 0, 0, 1, 1); cycle();
    set_instr(7'h33, 0, 0, 6, 1, 0); cycle();
    check("x0_nostall", last_stall, 0);

    // Flush together with a load-use hazard
    set_instr(7'h03, 1, 0, 5, 1, 1); cycle();
    set_instr(7'h33, 7, 5, 6, 1, 0); bus.flush = 1; cycle();
    check("fh_stall", last_stall, 0);
    check("fh_fcount", bus.flush_count, 1);
    check("fh_scount", bus.stall_count, 1);
    check("fh_valid", bus.ID_EXE_valid, 0);

    // Reset arriving while a stall is pending
    set_instr(7'h03, 1, 0, 5, 1, 1); cycle();
    set_instr(7'h33, 5, 2, 6, 1, 0); rst_n = 0; cycle();
    check("rs_pending_stall", last_stall, 1);
    cycle();
    check("rs_after_stall", last_stall, 0);
    check("rs_fcount", bus.flush_count, 0);
    rst_n = 1;

    // 20 load-use pairs saturate the stall counter
    for (int i = 0; i < 20; i++) begin
      set_instr(7'h03, 1, 0, 9, 1, 1); cycle();
      set_instr(7'h33, 9, 3, 4, 1, 0); cycle(); cycle();
    end
    check("sat_scount", bus.stall_count, CMAX);

    // Back-to-back flushes saturate the flush counter too
    for (int i = 0; i < 18; i++) begin rand_inputs(); bus.flush = 1; cycle(); end
    check("sat_fcount", bus.flush_count, CMAX);

    rst_n = 0; rand_inputs(); cycle(); rst_n = 1;
    for (int i = 0; i < 500; i++) begin
      if (!(last_stall && $urandom_range(0, 1) == 0)) rand_inputs();
      else bus.flush = ($urandom_range(0, 5) == 0);
      rst_n = ($urandom_range(0, 60) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/id_exe_stage_reg.md
# id_exe_stage_reg

Pipeline register between Decode and Execute, plus load-use hazard detection. It captures the decoded instruction each cycle and presents the `ID_EXE_*` fields to the forwarding unit and the ALU. It raises `stall_IF_ID` when a load in EXE feeds the instruction in ID, and inserts bubbles on stalls and branch flushes. Saturating stall and flush event counters support performance analysis.

## Interface
- `XLEN`, 64, width of data, immediate and PC fields
- `CNT_W`, 16, width of the stall and flush counters

Ports:
- `clk` input 1: rising-edge clock
- `rst_n` input 1: synchronous reset, active-low
- `ID_valid` input 1: ID holds a real instruction
- `ID_rs1`, `ID_rs2`, `ID_rd` input 5 each: decoded register indices
- `ID_OPCODE` input 7: decoded opcode
- `ID_RegWrite`, `ID_MemRead`, `ID_MemWrite` input 1 each: control bits
- `ID_rs1_data`, `ID_rs2_data`, `ID_imm`, `ID_pc` input XLEN each: operands, immediate, PC
- `flush` input 1: taken branch or jump resolved in EXE; kill the instruction in ID
- `ID_EXE_valid` output 1: EXE holds a real instruction
- `ID_EXE_rs1`, `ID_EXE_rs2`, `ID_EXE_rd` output 5 each: registered indices
- `ID_EXE_OPCODE` output 7: registered opcode
- `ID_EXE_RegWrite`, `ID_EXE_MemRead`, `ID_EXE_MemWrite` output 1 each: registered control bits
- `ID_EXE_rs1_data`, `ID_EXE_rs2_data`, `ID_EXE_imm`, `ID_EXE_pc` output XLEN each: registered data
- `stall_IF_ID` output 1: combinational; hold PC and the IF/ID register this cycle
- `stall_count`, `flush_count` output CNT_W each: saturating event counters

## Operation
- ID uses rs2 unless `ID_OPCODE` ∈ {7'h1b, 7'h13, 7'h03, 7'h6f, 7'h67, 7'h37, 7'h17}.
- ID uses rs1 unless `ID_OPCODE` ∈ {7'h37, 7'h17, 7'h6f}.
- hazard = `ID_valid` & `ID_EXE_valid` & `ID_EXE_MemRead` & (`ID_EXE_rd` ≠ 0) & ((uses_rs1 & `ID_EXE_rd`==`ID_rs1`) | (uses_rs2 & `ID_EXE_rd`==`ID_rs2`)).
- `stall_IF_ID` = hazard & ~`flush`. A flush kills the ID instruction, so it never stalls.
- Per rising edge, in priority order:
  1. `rst_n`=0: load bubble; both counters ← 0.
  2. `flush`=1: load bubble; `flush_count` += 1, saturating.
  3. hazard=1: load bubble; `stall_count` += 1, saturating.
  4. `ID_valid`=0: load bubble; no counter change.
  5. Otherwise: load every `ID_*` field into its `ID_EXE_*` register; `ID_EXE_valid` ← 1.
- Bubble contents: `ID_EXE_valid`, `ID_EXE_RegWrite`, `ID_EXE_MemRead` and `ID_EXE_MemWrite` = 0. `ID_EXE_rs1`, `ID_EXE_rs2` and `ID_EXE_rd` = 0, so forwarding never matches a bubble. `ID_EXE_OPCODE` = 7'h13 (NOP). All XLEN fields = 0.
- Counters hold at all-ones (2^CNT_W − 1) and never wrap.

## Timing
- Latency 1 cycle from ID inputs to `ID_EXE_*` outputs.
- `stall_IF_ID` has zero latency. It depends only on current inputs and current register state.
- Reset values: every output in the bubble state, counters 0, `stall_IF_ID` = 0.
- Load-use: exactly one bubble per load-use pair. On the next cycle the load has moved to MEM, so hazard drops. The held consumer is then captured with identical fields, and the forwarding unit supplies the load data from MEM/WB.
- Simultaneous flush and hazard: flush wins; `flush_count` increments, `stall_count` does not; `stall_IF_ID` = 0.
- Reset asserted mid-stall: the bubble is loaded and `stall_IF_ID` reads 0 on the cycle after reset is sampled.
- Back-to-back flushes: each cycle loads a bubble and increments `flush_count`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with random ID inputs. Required: `ID_EXE_valid`=0, `ID_EXE_OPCODE`=7'h13, rd/rs1/rs2=0, counters=0.
- Pass-through: issue `add x6,x5,x7` (opcode 7'h33, rs1=5, rs2=7, rd=6, RegWrite=1). Required: exact fields at `ID_EXE_*` one cycle later; `stall_IF_ID` stays 0.
- Load-use, rs2 live: `ld x5` (7'h03, MemRead=1, rd=5), then `add x6,x7,x5`. Required: `stall_IF_ID`=1 for exactly one cycle, one bubble, then the add appears; `stall_count`=1.
- No false stall: `ld x5`, then `addi x6,x1,imm` with rs2 field=5. Required: no stall. `ld x0`, then `add x6,x0,x0`. Required: no stall.
- Flush + hazard same cycle: load in EXE, dependent add in ID, `flush`=1. Required: bubble loaded, `stall_IF_ID`=0, `flush_count`=1, `stall_count` unchanged.
- Saturation: with `CNT_W`=4, force 20 load-use stalls. Required: `stall_count` reaches 15 and stays 15.
